load_store_unit: RTL

Memory-stage block directly downstream of the ALU/control datapath. It consumes memread/memwrite/memtoreg, funct_3, the ALU result (used as the effective address) and rs2 data. It runs a valid/ready transaction to data memory with byte enables, then aligns and sign/zero-extends load data. It produces register-file writeback data and a stall that gates pc_write.

---
 rtl/lsu_pkg.sv | 33 +++
 rtl/lsu_load_align.sv | 29 ++
 rtl/load_store_unit.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, funct_3 access codes,
// and the byte-enable helper used by both request generation and checking.
package lsu_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWaitRsp,
    StDone
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned NUM_LANES = 4;

  // Size lives in funct_3[1:0]; the unsigned variants share the byte-enable pattern.
  function automatic logic [NUM_LANES-1:0] byte_en(input logic [2:0] f3,
                                                   input logic [1:0] off);
    logic [NUM_LANES-1:0] be;
    be = 4'b1111;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: extracts the addressed byte/half/word lane from a memory word and
// sign- or zero-extends it to the register width.
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic [1:0]            i_offset,
  input  logic [2:0]            i_funct_3,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic [DATA_WIDTH-1:0] w_shifted;

  assign w_shifted = i_rdata >> {i_offset, 3'b000};

  always_comb begin
    o_data = w_shifted;
    case (i_funct_3)
      F3_B:    o_data = {{(DATA_WIDTH-8){w_shifted[7]}}, w_shifted[7:0]};
      F3_BU:   o_data = {{(DATA_WIDTH-8){1'b0}}, w_shifted[7:0]};
      F3_H:    o_data = {{(DATA_WIDTH-16){w_shifted[15]}}, w_shifted[15:0]};
      F3_HU:   o_data = {{(DATA_WIDTH-16){1'b0}}, w_shifted[15:0]};
      default: o_data = w_shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: valid/ready data-memory transaction, load alignment and
// writeback muxing. Optional watchdog enabled with `define LSU_TIMEOUT_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  memread,
  input  logic                  memwrite,
  input  logic                  memtoreg,
  input  logic [2:0]            funct_3,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic [DATA_WIDTH-1:0] store_data,
  output logic                  lsu_busy,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  wb_valid,
  output logic                  lsu_err,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_we,
  output logic [DATA_WIDTH-1:0] mem_req_addr,
  output logic [NUM_LANES-1:0]  mem_req_be,
  output logic [DATA_WIDTH-1:0] mem_req_wdata,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_rdata
);

  lsu_state_e            r_state, w_state_d;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [2:0]            r_f3;
  logic                  r_we;
  logic                  r_memtoreg;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_load;
  logic                  r_err;

  logic                  w_start;
  logic                  w_illegal;
  logic                  w_accept;
  logic                  w_err_d;
  logic                  w_timeout;
  logic [DATA_WIDTH-1:0] w_wdata_rep;
  logic [DATA_WIDTH-1:0] w_aligned;

  assign w_start = memread | memwrite;

  always_comb begin
    w_illegal = 1'b0;
    case (funct_3)
      F3_B, F3_BU: w_illegal = 1'b0;
      F3_H, F3_HU: w_illegal = alu_result[0];
      F3_W:        w_illegal = (alu_result[1:0] != 2'b00);
      default:     w_illegal = 1'b1;
    endcase
    if (memread && memwrite) w_illegal = 1'b1;
    // Stores have no unsigned variant.
    if (memwrite && funct_3[2]) w_illegal = 1'b1;
  end

  assign w_accept = (r_state == StIdle) && w_start && !w_illegal;

  always_comb begin
    w_wdata_rep = store_data;
    case (funct_3[1:0])
      2'b00:   w_wdata_rep = {4{store_data[7:0]}};
      2'b01:   w_wdata_rep = {2{store_data[15:0]}};
      default: w_wdata_rep = store_data;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
    end else if (r_state == StReq || r_state == StWaitRsp) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_state == StReq || r_state == StWaitRsp) &&
                     (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_cfg;

  assign w_unused_cfg = (CNT_W == 0) || (TIMEOUT_CYCLES == 0);
  assign w_timeout    = 1'b0;
`endif

  always_comb begin
    w_state_d = r_state;
    w_err_d   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_start) begin
          if (w_illegal) w_err_d   = 1'b1;
          else           w_state_d = StReq;
        end
      end
      StReq: begin
        if (w_timeout) begin
          w_state_d = StIdle;
          w_err_d   = 1'b1;
        end else if (mem_req_ready) begin
          w_state_d = r_we ? StDone : StWaitRsp;
        end
      end
      StWaitRsp: begin
        if (w_timeout) begin
          w_state_d = StIdle;
          w_err_d   = 1'b1;
        end else if (mem_rsp_valid) begin
          w_state_d = StDone;
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  lsu_load_align #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_align (
    .i_rdata  (mem_rsp_rdata),
    .i_offset (r_addr[1:0]),
    .i_funct_3(r_f3),
    .o_data   (w_aligned)
  );

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state    <= StIdle;
      r_addr     <= '0;
      r_f3       <= '0;
      r_we       <= 1'b0;
      r_memtoreg <= 1'b0;
      r_wdata    <= '0;
      r_load     <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_err   <= w_err_d;
      if (w_accept) begin
        r_addr     <= alu_result;
        r_f3       <= funct_3;
        r_we       <= memwrite;
        r_memtoreg <= memtoreg;
        r_wdata    <= w_wdata_rep;
      end
      if (r_state == StWaitRsp && mem_rsp_valid && !w_timeout) begin
        r_load <= w_aligned;
      end
    end
  end

  assign mem_req_valid = (r_state == StReq);
  assign mem_req_we    = r_we && (r_state == StReq);
  assign mem_req_addr  = {r_addr[DATA_WIDTH-1:2], 2'b00};
  assign mem_req_be    = (r_state == StReq) ? byte_en(r_f3, r_addr[1:0]) : '0;
  assign mem_req_wdata = r_wdata;

  assign lsu_busy = w_accept || (r_state == StReq) || (r_state == StWaitRsp);
  assign wb_valid = (r_state == StDone);
  assign lsu_err  = r_err;
  assign wb_data  = (r_state == StDone && !r_we && r_memtoreg) ? r_load : alu_result;

endmodule
